// File: rtl/bcd_counter_dual_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_dual_display
// Description : Two-digit BCD up/down counter with a run/pause/wait FSM, a
//               programmable prescaler that sets the count step rate, and
//               registered active-low 7-segment decodes for both digits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TICK_DIV  clock cycles per count step (2 .. 2**25)
// Ports
//   clk       system clock, rising-edge active
//   rst       synchronous active-high reset
//   start     level run-enable (from the power-on delay block)
//   pause     level, freezes counting while high
//   up        count direction: 1 = increment, 0 = decrement
//   bcd_ones  registered ones digit, 0-9
//   bcd_tens  registered tens digit, 0-9
//   seg_ones  active-low {g,f,e,d,c,b,a} for the ones digit (one cycle late)
//   seg_tens  active-low {g,f,e,d,c,b,a} for the tens digit (one cycle late)
//   tick      one-cycle pulse marking each count step
//   running   high while the FSM is in RUN
// ============================================================================
module bcd_counter_dual_display #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       up,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic [6:0] seg_ones,
    output logic [6:0] seg_tens,
    output logic       tick,
    output logic       running
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            PRESC_W   = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_EN = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PRESC_W-1:0] prescaler;
    logic               step_now;
    logic [3:0]         ones_nxt;
    logic [3:0]         tens_nxt;

    // ------------------------------------------------------------------------
    // Active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
    // Non-BCD inputs blank the display; they cannot occur in normal operation.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_EN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. Losing start always wins over pause.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_EN: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    state_nxt = WAIT_EN;
                end else if (pause) begin
                    state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (!start) begin
                    state_nxt = WAIT_EN;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = WAIT_EN;
            end
        endcase
    end

    // A count step happens on the edge where the prescaler sits at its
    // terminal value while in RUN. This depends only on the current state,
    // so a pause (or start drop) sampled on that same edge does not cancel
    // the step; the FSM leaves RUN after it.
    assign step_now = (state == RUN) && (prescaler == PRESC_MAX);

    // ------------------------------------------------------------------------
    // Prescaler: counts in RUN, holds in PAUSED, cleared in WAIT_EN so that a
    // restart always gives a full period before the first step.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (prescaler == PRESC_MAX) begin
                        prescaler <= '0;
                    end else begin
                        prescaler <= prescaler + PRESC_ONE;
                    end
                end
                PAUSED:  prescaler <= prescaler;
                default: prescaler <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // BCD next-value logic. Comparisons use >= 9 so that a corrupted digit
    // still recovers into the legal 0-9 range on the next step.
    // ------------------------------------------------------------------------
    always_comb begin
        ones_nxt = bcd_ones;
        tens_nxt = bcd_tens;
        if (up) begin
            if (bcd_ones >= DIGIT_MAX) begin
                ones_nxt = 4'd0;
                tens_nxt = (bcd_tens >= DIGIT_MAX) ? 4'd0 : bcd_tens + 4'd1;
            end else begin
                ones_nxt = bcd_ones + 4'd1;
            end
        end else begin
            if (bcd_ones == 4'd0 || bcd_ones > DIGIT_MAX) begin
                ones_nxt = DIGIT_MAX;
                tens_nxt = (bcd_tens == 4'd0 || bcd_tens > DIGIT_MAX) ?
                           DIGIT_MAX : bcd_tens - 4'd1;
            end else begin
                ones_nxt = bcd_ones - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Digits, tick and running. Digits only move on a step, so they are held
    // across PAUSED and WAIT_EN and a restart resumes from the held value.
    // running follows the next state so it lines up with the state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_ones <= 4'd0;
            bcd_tens <= 4'd0;
            tick     <= 1'b0;
            running  <= 1'b0;
        end else begin
            tick    <= step_now;
            running <= (state_nxt == RUN);
            if (step_now) begin
                bcd_ones <= ones_nxt;
                bcd_tens <= tens_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Segment outputs: registered decode of the digit registers, so they lag
    // the BCD outputs by one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_ones <= SEG_ZERO;
            seg_tens <= SEG_ZERO;
        end else begin
            seg_ones <= seg_decode(bcd_ones);
            seg_tens <= seg_decode(bcd_tens);
        end
    end

endmodule
`default_nettype wire

// File: doc/bcd_counter_dual_display.md
BCD_COUNTER_DUAL_DISPLAY -- requirements
Module: bcd_counter_dual_display

Interface
REQ-001 The module SHALL have a parameter TICK_DIV, default 25_000_000, giving the clock cycles per count step (0.5 s at 50 MHz); legal range is 2 to 2^25.
REQ-002 The module SHALL have port clk, input, 1 bit: the 50 MHz system clock, rising-edge active.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port start, input, 1 bit: level run-enable, driven by the power-on delay block's done output.
REQ-005 The module SHALL have port pause, input, 1 bit: level, freezes counting while high.
REQ-006 The module SHALL have port up, input, 1 bit: count direction, 1 = increment, 0 = decrement.
REQ-007 The module SHALL have port bcd_ones, output, 4 bits: registered ones digit, 0-9.
REQ-008 The module SHALL have port bcd_tens, output, 4 bits: registered tens digit, 0-9.
REQ-009 The module SHALL have port seg_ones, output, 7 bits: active-low segments {g,f,e,d,c,b,a} for the ones digit.
REQ-010 The module SHALL have port seg_tens, output, 7 bits: active-low segments {g,f,e,d,c,b,a} for the tens digit.
REQ-011 The module SHALL have port tick, output, 1 bit: one-cycle pulse marking each count step.
REQ-012 The module SHALL have port running, output, 1 bit: high while in state RUN.

Function
REQ-013 The module SHALL implement an FSM with states WAIT_EN, RUN and PAUSED.
- WAIT_EN -> RUN when start=1.
- RUN -> PAUSED when pause=1.
- PAUSED -> RUN when pause=0.
- RUN or PAUSED -> WAIT_EN when start=0; this has priority over pause.
REQ-014 The prescaler SHALL be ceil(log2(TICK_DIV)) bits wide and SHALL behave as follows:
- In RUN it counts 0 to TICK_DIV-1.
- On the cycle it equals TICK_DIV-1 it returns to 0.
- In PAUSED it holds its value.
- In WAIT_EN it is cleared to 0.
REQ-015 tick SHALL be registered and high for exactly one cycle, on the cycle after the prescaler equals TICK_DIV-1 in RUN; the tick period in RUN is exactly TICK_DIV cycles.
REQ-016 The BCD digits SHALL update on the same clock edge that asserts tick, with up sampled on that edge.
REQ-017 Increment SHALL follow these rules:
- ones 9 -> 0 with tens+1.
- 99 -> 00 wraps.
REQ-018 Decrement SHALL follow these rules:
- ones 0 -> 9 with tens-1.
- 00 -> 99 wraps.
REQ-019 The digits SHALL never hold a value above 9.
REQ-020 seg_ones and seg_tens SHALL be registered decodes of bcd_ones and bcd_tens, lagging them by one cycle, with these active-low codes:
- 0 = 7'b1000000
- 1 = 7'b1111001
- 2 = 7'b0100100
- 3 = 7'b0110000
- 4 = 7'b0011001
- 5 = 7'b0010010
- 6 = 7'b0000010
- 7 = 7'b1111000
- 8 = 7'b0000000
- 9 = 7'b0010000
REQ-021 Leaving RUN or PAUSED for WAIT_EN SHALL keep the digit values, so a restart resumes counting from the held value.
REQ-022 A change of up between ticks SHALL take effect only at the next tick.
REQ-023 If pause rises on the same edge that the prescaler reaches TICK_DIV-1, that tick SHALL still be issued, and the FSM SHALL enter PAUSED after it.
REQ-024 running SHALL be registered and SHALL equal (state == RUN).

Reset
REQ-025 While rst=1 at a rising edge, the module SHALL set the following on that edge:
- state = WAIT_EN
- prescaler = 0
- bcd_ones = 0, bcd_tens = 0
- seg_ones = seg_tens = 7'b1000000
- tick = 0
- running = 0
REQ-026 Reset SHALL override all other inputs, including a reset asserted mid-count or during PAUSED.
REQ-027 Counting SHALL resume only after rst=0 and start=1.

Verification
REQ-028 The bench SHALL cover these directed scenarios with TICK_DIV=4:
- Reset, then start=1, up=1 -> the first tick arrives 4 cycles after RUN entry, ticks repeat every 4 cycles, digits read 01, 02, 03.
- Count up from 98 -> 99 then 00; seg_tens goes 7'b0010000 -> 7'b1000000 one cycle after the BCD change.
- up=0 from 00 -> 99 then 98; ones digit 9 -> 0 -> 9 wrap checked; no digit ever exceeds 9.
- pause=1 for 10 cycles mid-period -> no tick, digits and prescaler frozen; after release the next tick arrives after the remaining period (4 minus cycles already elapsed).
- start 1 -> 0 at count 37 -> running=0, digits hold 37; start=1 again -> the next tick arrives exactly 4 cycles later and the value is 38.
- rst pulsed while in PAUSED at 55 -> next cycle all digits 0, segments 7'b1000000, state WAIT_EN even though start=1 is held, then RUN one cycle later.
